hack_control: RTL

- Multi-cycle Hack CPU controller; it is the driving end of the hack_alu control interface.
- Fetches 16-bit Hack instructions over a req/ack instruction port and decodes them.
- Drives the ALU operands and the six control bits (zX nX zY nY f no), consumes the ALU result, and updates the A, D and PC registers.
- Performs M reads and writes over a req/ack data port.

---
 rtl/hack_control.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hack_control.sv
// Multi-cycle Hack CPU controller: fetches and decodes instructions, steers the
// external hack_alu, and performs M reads/writes over a req/ack data port.
module hack_control #(
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic            dmem_rd,
  output logic            dmem_wr,
  output logic [PC_W-1:0] dmem_addr,
  output logic [15:0]     dmem_wdata,
  input  logic [15:0]     dmem_rdata,
  input  logic            dmem_ack,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output logic            zX,
  output logic            nX,
  output logic            zY,
  output logic            nY,
  output logic            f,
  output logic            no,
  input  logic [15:0]     alu_out,
  output logic [PC_W-1:0] pc,
  output logic            instr_done
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEMRD  = 3'd2,
    EXEC   = 3'd3,
    MEMWR  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     d_q, d_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     m_q, m_d;
  logic [15:0]     r_q, r_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic            imem_req_q, imem_req_d;
  logic            dmem_rd_q, dmem_rd_d;
  logic            dmem_wr_q, dmem_wr_d;
  logic [5:0]      ctrl_q, ctrl_d;
  logic            done;

  logic [PC_W-1:0] pc_inc;
  logic            zr, ng, taken;

  assign pc_inc = pc_q + PC_W'(1);
  assign zr     = (alu_out == 16'h0000);
  assign ng     = alu_out[15];
  assign taken  = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    d_d        = d_q;
    ir_d       = ir_q;
    m_d        = m_q;
    r_d        = r_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    imem_req_d = imem_req_q;
    dmem_rd_d  = dmem_rd_q;
    dmem_wr_d  = dmem_wr_q;
    ctrl_d     = ctrl_q;
    done       = 1'b0;

    case (state_q)
      FETCH: begin
        // Out of reset the request flop is low, so raise it before honouring any ack.
        if (!imem_req_q) begin
          imem_req_d = 1'b1;
        end else if (imem_ack) begin
          ir_d       = imem_data;
          imem_req_d = 1'b0;
          state_d    = DECODE;
        end
      end

      DECODE: begin
        if (!ir_q[15]) begin
          a_d        = {1'b0, ir_q[14:0]};
          pc_d       = pc_inc;
          done       = 1'b1;
          imem_req_d = 1'b1;
          state_d    = FETCH;
        end else if (ir_q[12]) begin
          addr_d    = a_q[PC_W-1:0];
          dmem_rd_d = 1'b1;
          state_d   = MEMRD;
        end else begin
          ctrl_d  = ir_q[11:6];
          state_d = EXEC;
        end
      end

      MEMRD: begin
        if (dmem_rd_q && dmem_ack) begin
          m_d       = dmem_rdata;
          dmem_rd_d = 1'b0;
          ctrl_d    = ir_q[11:6];
          state_d   = EXEC;
        end
      end

      EXEC: begin
        // Jump target and write address both come from A as it was before this instruction.
        ctrl_d = 6'b000000;
        if (ir_q[5]) a_d = alu_out;
        if (ir_q[4]) d_d = alu_out;
        pc_d = taken ? a_q[PC_W-1:0] : pc_inc;
        if (ir_q[3]) begin
          r_d       = alu_out;
          addr_d    = a_q[PC_W-1:0];
          dmem_wr_d = 1'b1;
          state_d   = MEMWR;
        end else begin
          done       = 1'b1;
          imem_req_d = 1'b1;
          state_d    = FETCH;
        end
      end

      MEMWR: begin
        if (dmem_wr_q && dmem_ack) begin
          dmem_wr_d  = 1'b0;
          done       = 1'b1;
          imem_req_d = 1'b1;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      a_q        <= 16'h0000;
      d_q        <= 16'h0000;
      ir_q       <= 16'h0000;
      m_q        <= 16'h0000;
      r_q        <= 16'h0000;
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      imem_req_q <= 1'b0;
      dmem_rd_q  <= 1'b0;
      dmem_wr_q  <= 1'b0;
      ctrl_q     <= 6'b000000;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      d_q        <= d_d;
      ir_q       <= ir_d;
      m_q        <= m_d;
      r_q        <= r_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      imem_req_q <= imem_req_d;
      dmem_rd_q  <= dmem_rd_d;
      dmem_wr_q  <= dmem_wr_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_rd    = dmem_rd_q;
  assign dmem_wr    = dmem_wr_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = r_q;
  assign alu_x      = d_q;
  assign alu_y      = ir_q[12] ? m_q : a_q;
  assign {zX, nX, zY, nY, f, no} = ctrl_q;
  assign pc         = pc_q;
  assign instr_done = done;

endmodule
